// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer.
//   ROB_OP_*     : 2-bit opcode encoding of a ROB entry
//   rob_entry_t  : per-entry payload (busy/ready/opcode/value/aux/pred_taken/flag)
//   rob_lookup   : operand lookup rule returning {ready, value}
package rob_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ROB_OP_REG    = 2'd0;
  localparam logic [1:0] ROB_OP_STORE  = 2'd1;
  localparam logic [1:0] ROB_OP_BRANCH = 2'd2;
  localparam logic [1:0] ROB_OP_JALR   = 2'd3;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [1:0]        opcode;
    logic [DATA_W-1:0] value;       // result, or PC+4 for JALR
    logic [DATA_W-1:0] aux;         // redirect PC (BRANCH) / target (JALR)
    logic              pred_taken;
    logic              flag;        // mispredict detected at writeback
  } rob_entry_t;

  // Operand lookup: a busy REG entry may be forwarded from a live writeback;
  // a busy JALR entry always exposes its link value.
  function automatic logic [DATA_W:0] rob_lookup(rob_entry_t ent, logic hit,
                                                  logic [DATA_W-1:0] fwd);
    logic [DATA_W:0] r;
    r = {ent.busy & ent.ready, ent.value};
    if (ent.busy && ent.opcode == ROB_OP_REG && hit) begin
      r = {1'b1, fwd};
    end else if (ent.busy && ent.opcode == ROB_OP_JALR) begin
      r = {1'b1, ent.value};
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer_mc_if.sv
// Bus bundle of the reorder buffer: issue, writeback, operand lookup and
// commit/flush outputs. master = fetch/execute side, slave = the ROB.
interface reorder_buffer_mc_if #(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned NUM_WB    = 3
);
  // issue
  logic                       issue_valid;
  logic [1:0]                 issue_opcode;
  logic                       issue_value_ready;
  logic [31:0]                issue_value;
  logic [31:0]                issue_aux;
  logic                       issue_pred_taken;
  logic [ROB_WIDTH-1:0]       rob_tag;
  logic                       full;
  logic                       empty;
  // writeback
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*ROB_WIDTH-1:0] wb_tag;
  logic [NUM_WB*32-1:0]       wb_value;
  // operand lookup
  logic [ROB_WIDTH-1:0]       rob_tag_rs1;
  logic [ROB_WIDTH-1:0]       rob_tag_rs2;
  logic                       rob_ready_rs1;
  logic                       rob_ready_rs2;
  logic [31:0]                rob_value_rs1;
  logic [31:0]                rob_value_rs2;
  // commit
  logic                       reg_done;
  logic [31:0]                reg_value;
  logic [ROB_WIDTH-1:0]       reg_tag;
  logic                       lsb_done;
  logic [ROB_WIDTH-1:0]       lsb_tag;
  logic                       predictor_signal;
  logic                       predictor_branch;
  logic                       clear_signal;
  logic [31:0]                correct_pc;

  modport master (
    output issue_valid, issue_opcode, issue_value_ready, issue_value, issue_aux,
           issue_pred_taken, wb_valid, wb_tag, wb_value, rob_tag_rs1, rob_tag_rs2,
    input  rob_tag, full, empty, rob_ready_rs1, rob_ready_rs2, rob_value_rs1,
           rob_value_rs2, reg_done, reg_value, reg_tag, lsb_done, lsb_tag,
           predictor_signal, predictor_branch, clear_signal, correct_pc
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_value_ready, issue_value, issue_aux,
           issue_pred_taken, wb_valid, wb_tag, wb_value, rob_tag_rs1, rob_tag_rs2,
    output rob_tag, full, empty, rob_ready_rs1, rob_ready_rs2, rob_value_rs1,
           rob_value_rs2, reg_done, reg_value, reg_tag, lsb_done, lsb_tag,
           predictor_signal, predictor_branch, clear_signal, correct_pc
  );
endinterface

// File: rtl/rob_wb_forward.sv
// Tag-match priority mux over the writeback channels; highest channel wins.
//   wb_valid/wb_tag/wb_value : flattened writeback channels
//   tag                      : tag being looked up
//   hit_c/value_c            : a live writeback targets tag, and its value
module rob_wb_forward
  import rob_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned NUM_WB    = 3
) (
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*ROB_WIDTH-1:0] wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]    wb_value,
  input  logic [ROB_WIDTH-1:0]        tag,
  output logic                        hit_c,
  output logic [DATA_W-1:0]           value_c
);

  always_comb begin
    hit_c   = 1'b0;
    value_c = '0;
    for (int k = 0; k < int'(NUM_WB); k++) begin
      if (wb_valid[k] && wb_tag[k*ROB_WIDTH +: ROB_WIDTH] == tag) begin
        hit_c   = 1'b1;
        value_c = wb_value[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: in-order issue, out-of-order writeback on NUM_WB channels,
// in-order single commit with branch/JALR mispredict flush.
//   clk_in, rst_n_in (async active-low), rdy_in (global enable)
//   bus : reorder_buffer_mc_if.slave (issue / writeback / lookup / commit)
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned NUM_WB    = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  reorder_buffer_mc_if.slave  bus
);

  localparam int unsigned ROB_SIZE = 1 << ROB_WIDTH;
  localparam int unsigned CNT_W    = ROB_WIDTH + 1;

  rob_entry_t           entries_q   [ROB_SIZE];
  rob_entry_t           entries_nxt [ROB_SIZE];
  logic [ROB_WIDTH-1:0] front_q, front_nxt, rear_q, rear_nxt;
  logic [CNT_W-1:0]     count_q, count_nxt;

  logic                 reg_done_q, reg_done_nxt;
  logic [DATA_W-1:0]    reg_value_q, reg_value_nxt;
  logic [ROB_WIDTH-1:0] reg_tag_q, reg_tag_nxt;
  logic                 lsb_done_q, lsb_done_nxt;
  logic [ROB_WIDTH-1:0] lsb_tag_q, lsb_tag_nxt;
  logic                 pred_sig_q, pred_sig_nxt;
  logic                 pred_br_q, pred_br_nxt;
  logic                 clear_q, clear_nxt;
  logic [DATA_W-1:0]    cpc_q, cpc_nxt;

  logic                 full_c;
  logic                 wb_hit_c [ROB_SIZE];
  logic [DATA_W-1:0]    wb_val_c [ROB_SIZE];
  logic                 fwd1_hit, fwd2_hit;
  logic [DATA_W-1:0]    fwd1_val, fwd2_val;
  rob_entry_t           head_c;
  logic                 commit_c, flush_c, issue_ok_c;

  assign full_c = (count_q == CNT_W'(ROB_SIZE));

  // Winning writeback per entry (highest channel wins on a shared tag).
  always_comb begin
    for (int e = 0; e < int'(ROB_SIZE); e++) begin
      wb_hit_c[e] = 1'b0;
      wb_val_c[e] = '0;
      for (int k = 0; k < int'(NUM_WB); k++) begin
        if (bus.wb_valid[k] && bus.wb_tag[k*ROB_WIDTH +: ROB_WIDTH] == ROB_WIDTH'(e)) begin
          wb_hit_c[e] = 1'b1;
          wb_val_c[e] = bus.wb_value[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next-state: writeback, commit, issue, then flush overrides all.
  always_comb begin
    for (int e = 0; e < int'(ROB_SIZE); e++) entries_nxt[e] = entries_q[e];
    front_nxt     = front_q;
    rear_nxt      = rear_q;
    count_nxt     = count_q;
    reg_done_nxt  = 1'b0;
    lsb_done_nxt  = 1'b0;
    pred_sig_nxt  = 1'b0;
    clear_nxt     = 1'b0;
    reg_value_nxt = reg_value_q;
    reg_tag_nxt   = reg_tag_q;
    lsb_tag_nxt   = lsb_tag_q;
    pred_br_nxt   = pred_br_q;
    cpc_nxt       = cpc_q;
    head_c        = entries_q[front_q];
    commit_c      = 1'b0;
    flush_c       = 1'b0;
    issue_ok_c    = 1'b0;

    if (rdy_in) begin
      // commit decision uses the pre-edge ready bit
      commit_c = head_c.busy && head_c.ready;

      if (!clear_q) begin
        for (int e = 0; e < int'(ROB_SIZE); e++) begin
          if (wb_hit_c[e] && entries_q[e].busy) begin
            entries_nxt[e].ready = 1'b1;
            case (entries_q[e].opcode)
              ROB_OP_BRANCH: entries_nxt[e].flag = wb_val_c[e][0] ^ entries_q[e].pred_taken;
              ROB_OP_JALR: begin
                entries_nxt[e].flag = (wb_val_c[e] != entries_q[e].aux);
                entries_nxt[e].aux  = wb_val_c[e];
              end
              default: entries_nxt[e].value = wb_val_c[e];
            endcase
          end
        end
      end

      if (commit_c) begin
        entries_nxt[front_q].busy = 1'b0;
        front_nxt = front_q + ROB_WIDTH'(1);
        case (head_c.opcode)
          ROB_OP_STORE: begin
            lsb_done_nxt = 1'b1;
            lsb_tag_nxt  = front_q;
          end
          ROB_OP_BRANCH: begin
            pred_sig_nxt = 1'b1;
            pred_br_nxt  = head_c.pred_taken ^ head_c.flag;
            flush_c      = head_c.flag;
          end
          default: begin
            reg_done_nxt  = 1'b1;
            reg_value_nxt = head_c.value;
            reg_tag_nxt   = front_q;
            flush_c       = head_c.flag && (head_c.opcode == ROB_OP_JALR);
          end
        endcase
      end

      issue_ok_c = bus.issue_valid && !full_c && !clear_q && !flush_c;
      if (issue_ok_c) begin
        entries_nxt[rear_q].busy       = 1'b1;
        entries_nxt[rear_q].ready      = bus.issue_value_ready;
        entries_nxt[rear_q].opcode     = bus.issue_opcode;
        entries_nxt[rear_q].value      = bus.issue_value;
        entries_nxt[rear_q].aux        = bus.issue_aux;
        entries_nxt[rear_q].pred_taken = bus.issue_pred_taken;
        entries_nxt[rear_q].flag       = 1'b0;
        rear_nxt = rear_q + ROB_WIDTH'(1);
      end

      count_nxt = count_q + CNT_W'(issue_ok_c) - CNT_W'(commit_c);

      if (flush_c) begin
        for (int e = 0; e < int'(ROB_SIZE); e++) entries_nxt[e].busy = 1'b0;
        rear_nxt  = front_q + ROB_WIDTH'(1);
        count_nxt = '0;
        clear_nxt = 1'b1;
        cpc_nxt   = head_c.aux;
      end
    end
  end

  // State and commit-output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int e = 0; e < int'(ROB_SIZE); e++) entries_q[e] <= '0;
      front_q     <= '0;
      rear_q      <= '0;
      count_q     <= '0;
      reg_done_q  <= 1'b0;
      reg_value_q <= '0;
      reg_tag_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_tag_q   <= '0;
      pred_sig_q  <= 1'b0;
      pred_br_q   <= 1'b0;
      clear_q     <= 1'b0;
      cpc_q       <= '0;
    end else begin
      for (int e = 0; e < int'(ROB_SIZE); e++) entries_q[e] <= entries_nxt[e];
      front_q     <= front_nxt;
      rear_q      <= rear_nxt;
      count_q     <= count_nxt;
      reg_done_q  <= reg_done_nxt;
      reg_value_q <= reg_value_nxt;
      reg_tag_q   <= reg_tag_nxt;
      lsb_done_q  <= lsb_done_nxt;
      lsb_tag_q   <= lsb_tag_nxt;
      pred_sig_q  <= pred_sig_nxt;
      pred_br_q   <= pred_br_nxt;
      clear_q     <= clear_nxt;
      cpc_q       <= cpc_nxt;
    end
  end

  rob_wb_forward #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) u_fwd_rs1 (
    .wb_valid(bus.wb_valid), .wb_tag(bus.wb_tag), .wb_value(bus.wb_value),
    .tag(bus.rob_tag_rs1), .hit_c(fwd1_hit), .value_c(fwd1_val)
  );

  rob_wb_forward #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) u_fwd_rs2 (
    .wb_valid(bus.wb_valid), .wb_tag(bus.wb_tag), .wb_value(bus.wb_value),
    .tag(bus.rob_tag_rs2), .hit_c(fwd2_hit), .value_c(fwd2_val)
  );

  assign {bus.rob_ready_rs1, bus.rob_value_rs1} =
    rob_lookup(entries_q[bus.rob_tag_rs1], fwd1_hit, fwd1_val);
  assign {bus.rob_ready_rs2, bus.rob_value_rs2} =
    rob_lookup(entries_q[bus.rob_tag_rs2], fwd2_hit, fwd2_val);

  assign bus.rob_tag          = rear_q;
  assign bus.full             = full_c;
  assign bus.empty            = (count_q == '0);
  assign bus.reg_done         = reg_done_q;
  assign bus.reg_value        = reg_value_q;
  assign bus.reg_tag          = reg_tag_q;
  assign bus.lsb_done         = lsb_done_q;
  assign bus.lsb_tag          = lsb_tag_q;
  assign bus.predictor_signal = pred_sig_q;
  assign bus.predictor_branch = pred_br_q;
  assign bus.clear_signal     = clear_q;
  assign bus.correct_pc       = cpc_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc: a program-order queue model
// predicts commits and lookups; a negedge monitor pops and compares commits.
module tb_reorder_buffer_mc;
  import rob_pkg::*;

  localparam int RW = 4;
  localparam int NW = 3;
  localparam int RS = 16;

  typedef struct {
    int          tag;
    logic [1:0]  op;
    logic [31:0] value;
    logic [31:0] aux;
    bit          pred;
    bit          rdy;
    bit          flag;
  } ment_t;

  typedef struct {
    int          kind;   // 0 reg, 1 store, 2 branch
    logic [31:0] value;
    int          tag;
    bit          branch;
    bit          clr;
    logic [31:0] pc;
  } exp_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;
  logic rdy_in   = 1'b1;
  always #5 clk_in = ~clk_in;

  reorder_buffer_mc_if #(.ROB_WIDTH(RW), .NUM_WB(NW)) bus ();

  reorder_buffer_mc #(.ROB_WIDTH(RW), .NUM_WB(NW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .bus(bus)
  );

  ment_t mq[$];
  exp_t  sb[$];
  int    m_rear = 0;
  bit    m_clr  = 0;
  bit    mon_en = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int wb_winner(int t);
    int w = -1;
    for (int k = 0; k < NW; k++)
      if (bus.wb_valid[k] && int'(bus.wb_tag[k*RW +: RW]) == t) w = k;
    return w;
  endfunction

  function automatic logic [31:0] wbv(int k);
    return bus.wb_value[k*32 +: 32];
  endfunction

  task automatic idle();
    rdy_in            = 1'b1;
    bus.issue_valid   = 1'b0;
    bus.issue_opcode  = ROB_OP_REG;
    bus.issue_value_ready = 1'b0;
    bus.issue_value   = '0;
    bus.issue_aux     = '0;
    bus.issue_pred_taken = 1'b0;
    bus.wb_valid      = '0;
    bus.wb_tag        = '0;
    bus.wb_value      = '0;
    bus.rob_tag_rs1   = '0;
    bus.rob_tag_rs2   = '0;
  endtask

  task automatic set_issue(logic [1:0] op, bit vr, logic [31:0] v, logic [31:0] a, bit p);
    bus.issue_valid = 1'b1; bus.issue_opcode = op; bus.issue_value_ready = vr;
    bus.issue_value = v; bus.issue_aux = a; bus.issue_pred_taken = p;
  endtask

  task automatic set_wb(int k, int tag, logic [31:0] v);
    bus.wb_valid[k] = 1'b1;
    bus.wb_tag[k*RW +: RW] = RW'(tag);
    bus.wb_value[k*32 +: 32] = v;
  endtask

  task automatic lookup_check(string nm, int t, logic rdy_a, logic [31:0] val_a);
    int idx = -1;
    int k;
    bit er = 0;
    logic [31:0] ev = '0;
    foreach (mq[i]) if (mq[i].tag == t) idx = i;
    if (idx >= 0) begin
      k = wb_winner(t);
      if (mq[idx].op == ROB_OP_REG && k >= 0) begin er = 1; ev = wbv(k); end
      else if (mq[idx].op == ROB_OP_JALR) begin er = 1; ev = mq[idx].value; end
      else begin er = mq[idx].rdy; ev = mq[idx].value; end
    end
    chk({nm, "_ready"}, 32'(rdy_a), 32'(er));
    if (er) chk({nm, "_value"}, val_a, ev);
  endtask

  // One clock: check lookups, advance the model, push expected commit, check state.
  task automatic step();
    ment_t hd;
    ment_t ne;
    exp_t  ex;
    bit    commit = 0, flush = 0, have = 0;
    int    sz, k;
    #1;
    lookup_check("lookup_rs1", int'(bus.rob_tag_rs1), bus.rob_ready_rs1, bus.rob_value_rs1);
    lookup_check("lookup_rs2", int'(bus.rob_tag_rs2), bus.rob_ready_rs2, bus.rob_value_rs2);
    if (rdy_in) begin
      sz = mq.size();
      commit = (sz > 0) && mq[0].rdy;
      if (commit) hd = mq[0];
      if (!m_clr) begin
        foreach (mq[i]) begin
          k = wb_winner(mq[i].tag);
          if (k >= 0) begin
            mq[i].rdy = 1;
            if (mq[i].op == ROB_OP_BRANCH) mq[i].flag = wbv(k)[0] ^ mq[i].pred;
            else if (mq[i].op == ROB_OP_JALR) begin
              mq[i].flag = (wbv(k) != mq[i].aux);
              mq[i].aux  = wbv(k);
            end else mq[i].value = wbv(k);
          end
        end
      end
      if (commit) begin
        void'(mq.pop_front());
        flush = (hd.op == ROB_OP_BRANCH || hd.op == ROB_OP_JALR) && hd.flag;
        ex.kind   = (hd.op == ROB_OP_STORE) ? 1 : (hd.op == ROB_OP_BRANCH) ? 2 : 0;
        ex.value  = hd.value;
        ex.tag    = hd.tag;
        ex.branch = hd.pred ^ hd.flag;
        ex.clr    = flush;
        ex.pc     = hd.aux;
        have = 1;
      end
      if (bus.issue_valid && sz < RS && !m_clr && !flush) begin
        ne.tag = m_rear; ne.op = bus.issue_opcode; ne.value = bus.issue_value;
        ne.aux = bus.issue_aux; ne.pred = bus.issue_pred_taken;
        ne.rdy = bus.issue_value_ready; ne.flag = 0;
        mq.push_back(ne);
        m_rear = (m_rear + 1) % RS;
      end
      if (flush) begin
        mq.delete();
        m_rear = (hd.tag + 1) % RS;
      end
      m_clr = flush;
    end else begin
      m_clr = 0;
    end
    @(posedge clk_in);
    if (have) sb.push_back(ex);
    #1;
    chk("full", 32'(bus.full), 32'(mq.size() == RS));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("rob_tag", 32'(bus.rob_tag), 32'(m_rear));
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_pulses", 32'({bus.reg_done, bus.lsb_done, bus.predictor_signal, bus.clear_signal}), 32'd0);
    chk("rst_rob_tag", 32'(bus.rob_tag), 32'd0);
    chk("rst_reg_value", bus.reg_value, 32'd0);
    chk("rst_correct_pc", bus.correct_pc, 32'd0);
    if (mon_en) chk("sb_drained_at_reset", 32'(sb.size()), 32'd0);
    sb.delete(); mq.delete(); m_rear = 0; m_clr = 0;
    idle();
    #1 rst_n_in = 1'b1;
    mon_en = 1;
    @(posedge clk_in);
    #1;
  endtask

  // Commit monitor: every negedge, compare DUT commit outputs against the scoreboard.
  initial begin
    exp_t e;
    logic [2:0] got, want;
    forever begin
      @(negedge clk_in);
      if (mon_en && rst_n_in) begin
        got = {bus.reg_done, bus.lsb_done, bus.predictor_signal};
        if (sb.size() > 0) begin
          e = sb.pop_front();
          want = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
          chk("commit_pulses", 32'(got), 32'(want));
          if (e.kind == 0) begin
            chk("reg_value", bus.reg_value, e.value);
            chk("reg_tag", 32'(bus.reg_tag), 32'(e.tag));
          end else if (e.kind == 1) begin
            chk("lsb_tag", 32'(bus.lsb_tag), 32'(e.tag));
          end else begin
            chk("predictor_branch", 32'(bus.predictor_branch), 32'(e.branch));
          end
          chk("clear_signal", 32'(bus.clear_signal), 32'(e.clr));
          if (e.clr) chk("correct_pc", bus.correct_pc, e.pc);
        end else if (got != 3'b000 || bus.clear_signal) begin
          chk("spurious_commit", 32'({got, bus.clear_signal}), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    idle();
    do_reset();

    // REG forwarded from writeback channel 1, then committed
    set_issue(ROB_OP_REG, 0, 32'h0, 32'h0, 0); step();
    idle(); set_wb(1, 0, 32'h55); step();
    idle(); step();
    idle(); step();

    // fill to full, drop 17th issue, commit once
    do_reset();
    for (int i = 0; i < RS; i++) begin
      idle(); set_issue(ROB_OP_REG, 0, 32'(i), 32'h0, 0); step();
    end
    idle(); set_issue(ROB_OP_REG, 1, 32'hdead, 32'h0, 0); step();
    idle(); set_wb(0, 0, 32'h77); step();
    idle(); step();

    // mispredicted branch flushes younger entries
    do_reset();
    idle(); set_issue(ROB_OP_BRANCH, 0, 32'h0, 32'h1000, 1); step();
    idle(); set_issue(ROB_OP_REG, 1, 32'h1, 32'h0, 0); step();
    idle(); set_issue(ROB_OP_REG, 1, 32'h2, 32'h0, 0); step();
    idle(); set_wb(0, 0, 32'h0); step();
    idle(); step();
    idle(); set_issue(ROB_OP_REG, 1, 32'h3, 32'h0, 0); set_wb(2, 1, 32'h9); step();
    idle(); step();

    // JALR correct then wrong target
    do_reset();
    idle(); set_issue(ROB_OP_JALR, 0, 32'h204, 32'h300, 0); step();
    idle(); set_wb(2, 0, 32'h300); step();
    idle(); step();
    idle(); set_issue(ROB_OP_JALR, 0, 32'h204, 32'h300, 0); step();
    idle(); bus.rob_tag_rs1 = RW'(1); set_wb(1, 1, 32'h400); step();
    idle(); step();
    idle(); step();

    // same-cycle double hit on tag 3: highest channel forwards
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); set_issue(ROB_OP_REG, 0, 32'h0, 32'h0, 0); step();
    end
    idle(); bus.rob_tag_rs1 = RW'(3); set_wb(0, 3, 32'h11); set_wb(2, 3, 32'h22); step();

    // reset with busy entries, then stale writebacks must not commit
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); set_issue(ROB_OP_REG, 0, 32'(i), 32'h0, 0); step();
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); set_wb(0, i, 32'(i + 100)); step();
    end

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      int o;
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) begin
        o = $urandom_range(0, 5);
        set_issue(2'(o > 3 ? 0 : o), $urandom_range(0, 3) == 0, $urandom, $urandom,
                  $urandom_range(0, 1) == 1);
      end
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, mq.size() - 1);
            set_wb(k, mq[idx].tag,
                   (mq[idx].op == ROB_OP_JALR && $urandom_range(0, 1) == 1) ? mq[idx].aux : $urandom);
          end else begin
            set_wb(k, $urandom_range(0, RS - 1), $urandom);
          end
        end
      end
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        bus.rob_tag_rs1 = RW'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        bus.rob_tag_rs1 = RW'($urandom_range(0, RS - 1));
      bus.rob_tag_rs2 = RW'($urandom_range(0, RS - 1));
      step();
    end

    // drain
    for (int c = 0; c < 300 && mq.size() > 0; c++) begin
      idle();
      if (!mq[0].rdy) set_wb(0, mq[0].tag, $urandom);
      step();
    end
    chk("drain_done", 32'(mq.size()), 32'd0);
    idle(); step();
    idle(); step();
    @(negedge clk_in);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
